// File: rtl/otter_mem_align_ctrl_if.sv
// Bus bundle between the MEM stage / data memory port 2 and the alignment sequencer.
// slave is the sequencer's view; master is the pipeline-plus-memory side.
interface otter_mem_align_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [1:0]           req_size;
  logic                 req_sign;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic [31:0]          mem_addr2;
  logic [31:0]          mem_din2;
  logic                 mem_write2;
  logic                 mem_read2;
  logic [1:0]           mem_size;
  logic                 mem_sign;
  logic [31:0]          mem_dout2;
  logic [CNT_WIDTH-1:0] split_cnt;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
    output req_ready, rsp_valid, rsp_rdata, mem_addr2, mem_din2, mem_write2,
           mem_read2, mem_size, mem_sign, split_cnt
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_sign, mem_dout2,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr2, mem_din2, mem_write2,
           mem_read2, mem_size, mem_sign, split_cnt
  );
endinterface

// File: rtl/otter_mem_align_ctrl.sv
// Splits word-crossing loads/stores from the MEM stage into aligned word reads
// or byte writes on memory port 2, and merges/extends load data itself.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | ready for a request
// ST_RD_LO   | read strobe for the (first) word
// ST_CAP_LO  | capture first word from memory
// ST_RD_HI   | read strobe for the following word (crossing loads)
// ST_CAP_HI  | capture second word
// ST_WR      | single pass-through write
// ST_WR_BYTE | one byte of a crossing store per cycle
// ST_DONE    | completion pulse, result presented
module otter_mem_align_ctrl #(
  parameter logic [31:0] IO_BASE   = 32'h1100_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  otter_mem_align_ctrl_if.slave  io_bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_LO, ST_CAP_LO, ST_RD_HI, ST_CAP_HI, ST_WR, ST_WR_BYTE, ST_DONE
  } state_t;

  state_t               r_state;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [1:0]           r_size;
  logic                 r_sign;
  logic                 r_io;
  logic                 r_cross;
  logic [31:0]          r_lo;
  logic [31:0]          r_hi;
  logic [1:0]           r_k;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_rdata;
  logic [31:0]          r_mem_addr2;
  logic [31:0]          r_mem_din2;
  logic                 r_mem_write2;
  logic                 r_mem_read2;
  logic [1:0]           r_mem_size;
  logic                 r_mem_sign;
  logic [CNT_WIDTH-1:0] r_split_cnt;

  logic        w_accept;
  logic        w_req_io;
  logic        w_req_cross;
  logic [1:0]  w_off;
  logic [31:0] w_word_hi;
  logic [31:0] w_lo_now;
  logic [31:0] w_hi_now;
  logic [63:0] w_cat;
  logic [31:0] w_merged;
  logic [31:0] w_load_res;
  logic [1:0]  w_k_next;
  logic [1:0]  w_k_last;
  logic [7:0]  w_byte_next;

  assign w_accept    = io_bus.req_valid && r_req_ready;
  assign w_off       = io_bus.req_addr[1:0];
  assign w_req_io    = (io_bus.req_addr >= IO_BASE);
  assign w_req_cross = !w_req_io &&
                       (((io_bus.req_size == 2'd1) && (w_off == 2'd3)) ||
                        ((io_bus.req_size == 2'd2) && (w_off != 2'd0)));

  assign w_word_hi   = {r_addr[31:2], 2'b00} + 32'd4;
  assign w_k_next    = r_k + 2'd1;
  assign w_k_last    = (r_size == 2'd1) ? 2'd1 : 2'd3;
  assign w_byte_next = 8'(r_wdata >> {w_k_next, 3'b000});

  // The word being captured this cycle feeds the result directly so the
  // response can be registered on the same edge that ends the capture.
  assign w_lo_now = (r_state == ST_CAP_LO) ? io_bus.mem_dout2 : r_lo;
  assign w_hi_now = (r_state == ST_CAP_HI) ? io_bus.mem_dout2 : r_hi;
  assign w_cat    = {w_hi_now, w_lo_now};
  assign w_merged = 32'(w_cat >> {r_addr[1:0], 3'b000});

  always_comb begin
    w_load_res = w_merged;
    if (r_io) begin
      w_load_res = w_lo_now;
    end else begin
      case (r_size)
        2'd0:    w_load_res = r_sign ? {24'b0, w_merged[7:0]}  : {{24{w_merged[7]}},  w_merged[7:0]};
        2'd1:    w_load_res = r_sign ? {16'b0, w_merged[15:0]} : {{16{w_merged[15]}}, w_merged[15:0]};
        default: w_load_res = w_merged;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_sign       <= 1'b0;
      r_io         <= 1'b0;
      r_cross      <= 1'b0;
      r_lo         <= '0;
      r_hi         <= '0;
      r_k          <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_mem_addr2  <= '0;
      r_mem_din2   <= '0;
      r_mem_write2 <= 1'b0;
      r_mem_read2  <= 1'b0;
      r_mem_size   <= 2'd2;
      r_mem_sign   <= 1'b0;
      r_split_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= io_bus.req_addr;
            r_wdata     <= io_bus.req_wdata;
            r_size      <= io_bus.req_size;
            r_sign      <= io_bus.req_sign;
            r_io        <= w_req_io;
            r_cross     <= w_req_cross;
            r_lo        <= '0;
            r_hi        <= '0;
            r_k         <= '0;
            r_req_ready <= 1'b0;
            if (w_req_cross && !(&r_split_cnt))
              r_split_cnt <= r_split_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (io_bus.req_size == 2'd3) begin
              r_state     <= ST_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (!io_bus.req_we) begin
              r_state     <= ST_RD_LO;
              r_mem_read2 <= 1'b1;
              if (w_req_io) begin
                r_mem_addr2 <= io_bus.req_addr;
                r_mem_size  <= io_bus.req_size;
                r_mem_sign  <= io_bus.req_sign;
              end else begin
                r_mem_addr2 <= {io_bus.req_addr[31:2], 2'b00};
                r_mem_size  <= 2'd2;
                r_mem_sign  <= 1'b0;
              end
            end else if (w_req_cross) begin
              r_state      <= ST_WR_BYTE;
              r_mem_write2 <= 1'b1;
              r_mem_size   <= 2'd0;
              r_mem_addr2  <= io_bus.req_addr;
              r_mem_din2   <= {24'b0, io_bus.req_wdata[7:0]};
            end else begin
              r_state      <= ST_WR;
              r_mem_write2 <= 1'b1;
              r_mem_size   <= io_bus.req_size;
              r_mem_addr2  <= io_bus.req_addr;
              r_mem_din2   <= io_bus.req_wdata;
            end
          end
        end
        ST_RD_LO: begin
          r_mem_read2 <= 1'b0;
          r_state     <= ST_CAP_LO;
        end
        ST_CAP_LO: begin
          r_lo <= io_bus.mem_dout2;
          if (r_cross) begin
            r_state     <= ST_RD_HI;
            r_mem_read2 <= 1'b1;
            r_mem_addr2 <= w_word_hi;
          end else begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load_res;
            r_mem_size  <= 2'd2;
            r_mem_sign  <= 1'b0;
          end
        end
        ST_RD_HI: begin
          r_mem_read2 <= 1'b0;
          r_state     <= ST_CAP_HI;
        end
        ST_CAP_HI: begin
          r_hi        <= io_bus.mem_dout2;
          r_state     <= ST_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load_res;
          r_mem_size  <= 2'd2;
          r_mem_sign  <= 1'b0;
        end
        ST_WR: begin
          r_mem_write2 <= 1'b0;
          r_mem_din2   <= '0;
          r_mem_size   <= 2'd2;
          r_state      <= ST_DONE;
          r_rsp_valid  <= 1'b1;
          r_rsp_rdata  <= '0;
        end
        ST_WR_BYTE: begin
          if (r_k == w_k_last) begin
            r_mem_write2 <= 1'b0;
            r_mem_din2   <= '0;
            r_mem_size   <= 2'd2;
            r_state      <= ST_DONE;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= '0;
          end else begin
            r_k         <= w_k_next;
            r_mem_addr2 <= r_addr + 32'(w_k_next);
            r_mem_din2  <= {24'b0, w_byte_next};
          end
        end
        ST_DONE: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.req_ready  = r_req_ready;
  assign io_bus.rsp_valid  = r_rsp_valid;
  assign io_bus.rsp_rdata  = r_rsp_rdata;
  assign io_bus.mem_addr2  = r_mem_addr2;
  assign io_bus.mem_din2   = r_mem_din2;
  assign io_bus.mem_write2 = r_mem_write2;
  assign io_bus.mem_read2  = r_mem_read2;
  assign io_bus.mem_size   = r_mem_size;
  assign io_bus.mem_sign   = r_mem_sign;
  assign io_bus.split_cnt  = r_split_cnt;

endmodule

// File: tb/tb_otter_mem_align_ctrl.sv
// Directed bench for otter_mem_align_ctrl: a vector table of single requests
// against a byte-array memory model, plus crossing-store, MMIO and reset sequences.
module tb_otter_mem_align_ctrl;

  localparam int CNT_WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otter_mem_align_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  otter_mem_align_ctrl #(.IO_BASE(32'h1100_0000), .CNT_WIDTH(CNT_WIDTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]  mem [0:4095];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_din[$];
  logic [1:0]  wq_size[$];
  int          wq_cyc[$];
  logic [31:0] rq_addr[$];
  int          rq_cyc[$];

  // Memory model: writes land on the edge, read data is valid the next cycle.
  always @(posedge clk) begin
    if (bus.mem_write2) begin
      mem[bus.mem_addr2[11:0]] <= bus.mem_din2[7:0];
      if (bus.mem_size != 2'd0) mem[bus.mem_addr2[11:0] + 12'd1] <= bus.mem_din2[15:8];
      if (bus.mem_size == 2'd2) begin
        mem[bus.mem_addr2[11:0] + 12'd2] <= bus.mem_din2[23:16];
        mem[bus.mem_addr2[11:0] + 12'd3] <= bus.mem_din2[31:24];
      end
      wq_addr.push_back(bus.mem_addr2);
      wq_din.push_back(bus.mem_din2);
      wq_size.push_back(bus.mem_size);
      wq_cyc.push_back(cyc);
    end
    if (bus.mem_read2) begin
      bus.mem_dout2 <= {mem[bus.mem_addr2[11:0] + 12'd3], mem[bus.mem_addr2[11:0] + 12'd2],
                        mem[bus.mem_addr2[11:0] + 12'd1], mem[bus.mem_addr2[11:0]]};
      rq_addr.push_back(bus.mem_addr2);
      rq_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put_word(input logic [11:0] a, input logic [31:0] w);
    mem[a]         = w[7:0];
    mem[a + 12'd1] = w[15:8];
    mem[a + 12'd2] = w[23:16];
    mem[a + 12'd3] = w[31:24];
  endtask

  task automatic clear_logs();
    wq_addr.delete(); wq_din.delete(); wq_size.delete(); wq_cyc.delete();
    rq_addr.delete(); rq_cyc.delete();
  endtask

  // Issues one request; lat is the cycle of RSP_VALID relative to accept (-1 if none).
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sign,
                         output int lat, output logic [31:0] rdata, output int acc);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_size  = size;
    bus.req_sign  = sign;
    @(posedge clk);
    lat   = -1;
    rdata = 'x;
    acc   = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.req_valid = 1'b0;
        acc = cyc - 1;
      end
      if (bus.rsp_valid) begin
        lat   = n;
        rdata = bus.rsp_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_split;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_rd0;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          acc;
    int          pulses;
    int          strobes;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF, 3, 0, 1, 0, 32'h0000_0100};
    vecs[1]  = '{1'b0, 32'h0000_0203, 32'h0,         2'd2, 1'b0, 32'h7766_5544, 5, 1, 2, 0, 32'h0000_0200};
    vecs[2]  = '{1'b0, 32'h0000_0307, 32'h0,         2'd1, 1'b0, 32'hFFFF_9988, 5, 2, 2, 0, 32'h0000_0304};
    vecs[3]  = '{1'b0, 32'h0000_0307, 32'h0,         2'd1, 1'b1, 32'h0000_9988, 5, 3, 2, 0, 32'h0000_0304};
    vecs[4]  = '{1'b0, 32'h0000_0101, 32'h0,         2'd0, 1'b0, 32'hFFFF_FFBE, 3, 3, 1, 0, 32'h0000_0100};
    vecs[5]  = '{1'b0, 32'h0000_0101, 32'h0,         2'd0, 1'b1, 32'h0000_00BE, 3, 3, 1, 0, 32'h0000_0100};
    vecs[6]  = '{1'b0, 32'h0000_0102, 32'h0,         2'd1, 1'b0, 32'hFFFF_DEAD, 3, 3, 1, 0, 32'h0000_0100};
    vecs[7]  = '{1'b0, 32'h1100_0000, 32'h0,         2'd2, 1'b0, 32'h5A5A_A5C3, 3, 3, 1, 0, 32'h1100_0000};
    vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd3, 1'b0, 32'h0,         1, 3, 0, 0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 2'd2, 1'b0, 32'h0,         2, 3, 0, 1, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0400, 32'h0,         2'd2, 1'b0, 32'h1234_5678, 3, 3, 1, 0, 32'h0000_0400};
    vecs[11] = '{1'b0, 32'h0000_0203, 32'h0,         2'd1, 1'b1, 32'h0000_5544, 5, 4, 2, 0, 32'h0000_0200};
    vecs[12] = '{1'b1, 32'h0000_040B, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0,         3, 5, 0, 2, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0408, 32'h0,         2'd2, 1'b0, 32'hEF00_0000, 3, 5, 1, 0, 32'h0000_0408};
    vecs[14] = '{1'b0, 32'h0000_040C, 32'h0,         2'd2, 1'b0, 32'h0000_00BE, 3, 5, 1, 0, 32'h0000_040C};
    vecs[15] = '{1'b1, 32'h0000_0403, 32'hFFFF_FF99, 2'd0, 1'b0, 32'h0,         2, 5, 0, 1, 32'h0};
    vecs[16] = '{1'b0, 32'h0000_0400, 32'h0,         2'd2, 1'b0, 32'h9934_5678, 3, 5, 1, 0, 32'h0000_0400};
    vecs[17] = '{1'b1, 32'h0000_0100, 32'h0,         2'd3, 1'b0, 32'h0,         1, 5, 0, 0, 32'h0};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    put_word(12'h000, 32'h5A5A_A5C3);
    put_word(12'h100, 32'hDEAD_BEEF);
    put_word(12'h104, 32'h1122_3344);
    put_word(12'h200, 32'h4433_2211);
    put_word(12'h204, 32'h8877_6655);
    put_word(12'h304, 32'h8877_6655);
    put_word(12'h308, 32'h0000_0099);

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_size  = 2'd0;
    bus.req_sign  = 1'b0;
    bus.mem_dout2 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_rsp_valid",  {31'b0, bus.rsp_valid},  32'd0);
    chk("rst_rsp_rdata",  bus.rsp_rdata,           32'd0);
    chk("rst_mem_read2",  {31'b0, bus.mem_read2},  32'd0);
    chk("rst_mem_write2", {31'b0, bus.mem_write2}, 32'd0);
    chk("rst_mem_din2",   bus.mem_din2,            32'd0);
    chk("rst_mem_addr2",  bus.mem_addr2,           32'd0);
    chk("rst_mem_size",   {30'b0, bus.mem_size},   32'd2);
    chk("rst_mem_sign",   {31'b0, bus.mem_sign},   32'd0);
    chk("rst_split_cnt",  32'(bus.split_cnt),      32'd0);

    for (int i = 0; i < NV; i++) begin
      clear_logs();
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign, lat, rd, acc);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_split_cnt", i), 32'(bus.split_cnt), 32'(vecs[i].exp_split));
      chk($sformatf("vec%0d_num_reads", i), 32'(rq_addr.size()), 32'(vecs[i].exp_nrd));
      chk($sformatf("vec%0d_num_writes", i), 32'(wq_addr.size()), 32'(vecs[i].exp_nwr));
      if (rq_addr.size() > 0) begin
        chk($sformatf("vec%0d_rd0_addr", i), rq_addr[0], vecs[i].exp_rd0);
        chk($sformatf("vec%0d_rd0_cycle", i), 32'(rq_cyc[0] - acc), 32'd1);
      end
      if (rq_addr.size() > 1)
        chk($sformatf("vec%0d_rd1_addr", i), rq_addr[1], vecs[i].exp_rd0 + 32'd4);
    end

    // Crossing word store: four byte writes in cycles 1-4, response in cycle 5.
    clear_logs();
    run_req(1'b1, 32'h0000_0102, 32'hAABB_CCDD, 2'd2, 1'b0, lat, rd, acc);
    chk("xsw_latency", 32'(lat), 32'd5);
    chk("xsw_num_writes", 32'(wq_addr.size()), 32'd4);
    chk("xsw_split_cnt", 32'(bus.split_cnt), 32'd6);
    if (wq_addr.size() == 4) begin
      logic [31:0] exp_din [4];
      exp_din[0] = 32'hDD; exp_din[1] = 32'hCC; exp_din[2] = 32'hBB; exp_din[3] = 32'hAA;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("xsw_wr%0d_addr", k), wq_addr[k], 32'h0000_0102 + 32'(k));
        chk($sformatf("xsw_wr%0d_din", k), wq_din[k], exp_din[k]);
        chk($sformatf("xsw_wr%0d_size", k), {30'b0, wq_size[k]}, 32'd0);
        chk($sformatf("xsw_wr%0d_cycle", k), 32'(wq_cyc[k] - acc), 32'(k + 1));
      end
    end
    run_req(1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0, lat, rd, acc);
    chk("xsw_readback_lo", rd, 32'hCCDD_BEEF);
    run_req(1'b0, 32'h0000_0104, 32'h0, 2'd2, 1'b0, lat, rd, acc);
    chk("xsw_readback_hi", rd, 32'h1122_AABB);

    // MMIO store at an unaligned address passes through unsplit.
    clear_logs();
    run_req(1'b1, 32'h1100_0003, 32'h0102_0304, 2'd2, 1'b0, lat, rd, acc);
    chk("io_sw_latency", 32'(lat), 32'd2);
    chk("io_sw_num_writes", 32'(wq_addr.size()), 32'd1);
    chk("io_sw_split_cnt", 32'(bus.split_cnt), 32'd6);
    if (wq_addr.size() == 1) begin
      chk("io_sw_addr", wq_addr[0], 32'h1100_0003);
      chk("io_sw_din",  wq_din[0],  32'h0102_0304);
      chk("io_sw_size", {30'b0, wq_size[0]}, 32'd2);
    end

    // Reset during cycle 2 of a crossing store: only the first two bytes land.
    put_word(12'h104, 32'h0000_0000);
    clear_logs();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0102;
    bus.req_wdata = 32'h5566_7788;
    bus.req_size  = 2'd2;
    bus.req_sign  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_req_ready", {31'b0, bus.req_ready},  32'd1);
    chk("rstmid_write2",    {31'b0, bus.mem_write2}, 32'd0);
    chk("rstmid_split_cnt", 32'(bus.split_cnt),      32'd0);
    pulses  = 0;
    strobes = 0;
    for (int n = 0; n < 6; n++) begin
      if (bus.rsp_valid) pulses++;
      if (bus.mem_write2) strobes++;
      @(negedge clk);
    end
    chk("rstmid_rsp_pulses", 32'(pulses), 32'd0);
    chk("rstmid_late_strobes", 32'(strobes), 32'd0);
    chk("rstmid_num_writes", 32'(wq_addr.size()), 32'd2);
    chk("rstmid_byte102", {24'b0, mem[12'h102]}, 32'h88);
    chk("rstmid_byte103", {24'b0, mem[12'h103]}, 32'h77);
    chk("rstmid_byte104", {24'b0, mem[12'h104]}, 32'h00);
    run_req(1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0, lat, rd, acc);
    chk("rstmid_recover_latency", 32'(lat), 32'd3);
    chk("rstmid_recover_rdata", rd, 32'h7788_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
